// File: rtl/anton_neopixel_bus_arbiter.sv
// rtl/anton_neopixel_bus_arbiter.sv - two-requester round-robin arbiter for the neopixel bus
// Serialises A/B byte accesses with a ready timeout and defers frame commits until the bus is idle.
module anton_neopixel_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        apbPclk,
  input  logic        apbPresern,
  input  logic        reqA,
  input  logic        reqB,
  input  logic        wrA,
  input  logic        wrB,
  input  logic [17:0] addrA,
  input  logic [17:0] addrB,
  input  logic [7:0]  wdataA,
  input  logic [7:0]  wdataB,
  input  logic        commitA,
  input  logic        commitB,
  output logic        doneA,
  output logic        doneB,
  output logic        errA,
  output logic        errB,
  output logic [7:0]  rdata,
  output logic [17:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busRead,
  input  logic [7:0]  busDataOut,
  input  logic        busReady,
  output logic        syncStart
);

  typedef enum logic [1:0] {IDLE, ACCESS, SYNC} state_t;

  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t     state, stateNext;
  logic       pointer;
  logic       grantB, grantBNext;
  logic       isWrite;
  logic       commitPending;
  logic [9:0] counter;
  logic       startAccess, finishOk, finishTimeout;
  logic       effA, effB;

  // A requester still sees its own done pulse while it lowers req; masking it
  // prevents the same access from being granted a second time.
  assign effA = reqA & ~doneA;
  assign effB = reqB & ~doneB;

  assign syncStart = (state == SYNC);

  always_comb begin
    stateNext     = state;
    grantBNext    = grantB;
    startAccess   = 1'b0;
    finishOk      = 1'b0;
    finishTimeout = 1'b0;
    case (state)
      IDLE: begin
        if (commitPending) begin
          stateNext = SYNC;
        end else if (effA | effB) begin
          startAccess = 1'b1;
          stateNext   = ACCESS;
          grantBNext  = effB & (~effA | pointer);
        end
      end
      ACCESS: begin
        if (busReady) begin
          finishOk  = 1'b1;
          stateNext = IDLE;
        end else if (counter == TIMEOUT_LAST) begin
          finishTimeout = 1'b1;
          stateNext     = IDLE;
        end
      end
      SYNC: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge apbPclk or negedge apbPresern) begin
    if (!apbPresern) begin
      state         <= IDLE;
      pointer       <= 1'b0;
      grantB        <= 1'b0;
      isWrite       <= 1'b0;
      commitPending <= 1'b0;
      counter       <= 10'd0;
      busAddr       <= 18'd0;
      busDataIn     <= 8'd0;
      busWrite      <= 1'b0;
      busRead       <= 1'b0;
      doneA         <= 1'b0;
      doneB         <= 1'b0;
      errA          <= 1'b0;
      errB          <= 1'b0;
      rdata         <= 8'd0;
    end else begin
      state         <= stateNext;
      grantB        <= grantBNext;
      commitPending <= commitA | commitB | (commitPending & (state != SYNC));
      doneA         <= 1'b0;
      doneB         <= 1'b0;
      errA          <= 1'b0;
      errB          <= 1'b0;
      rdata         <= 8'd0;
      if (startAccess) begin
        busAddr   <= grantBNext ? addrB : addrA;
        busDataIn <= grantBNext ? wdataB : wdataA;
        isWrite   <= grantBNext ? wrB : wrA;
        busWrite  <= grantBNext ? wrB : wrA;
        busRead   <= grantBNext ? ~wrB : ~wrA;
        counter   <= 10'd0;
      end else if (state == ACCESS && !busReady) begin
        counter <= counter + 10'd1;
      end
      if (finishOk || finishTimeout) begin
        busWrite <= 1'b0;
        busRead  <= 1'b0;
        doneA    <= ~grantB;
        doneB    <= grantB;
        errA     <= finishTimeout & ~grantB;
        errB     <= finishTimeout & grantB;
        rdata    <= (finishOk && !isWrite) ? busDataOut : 8'd0;
        pointer  <= ~grantB;
      end
    end
  end

endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// tb/tb_anton_neopixel_bus_arbiter.sv - scoreboard bench for anton_neopixel_bus_arbiter
// Expected completions are queued as stimulus is applied and matched against each done pulse.
module tb_anton_neopixel_bus_arbiter;

  logic        apbPclk = 1'b0;
  logic        apbPresern = 1'b0;
  logic        reqA = 1'b0, reqB = 1'b0, wrA = 1'b0, wrB = 1'b0;
  logic [17:0] addrA = '0, addrB = '0;
  logic [7:0]  wdataA = '0, wdataB = '0;
  logic        commitA = 1'b0, commitB = 1'b0;
  logic        doneA, doneB, errA, errB;
  logic [7:0]  rdata;
  logic [17:0] busAddr;
  logic [7:0]  busDataIn;
  logic        busWrite, busRead;
  logic [7:0]  busDataOut = '0;
  logic        busReady = 1'b0;
  logic        syncStart;

  anton_neopixel_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .apbPclk(apbPclk), .apbPresern(apbPresern),
    .reqA(reqA), .reqB(reqB), .wrA(wrA), .wrB(wrB),
    .addrA(addrA), .addrB(addrB), .wdataA(wdataA), .wdataB(wdataB),
    .commitA(commitA), .commitB(commitB),
    .doneA(doneA), .doneB(doneB), .errA(errA), .errB(errB), .rdata(rdata),
    .busAddr(busAddr), .busDataIn(busDataIn), .busWrite(busWrite), .busRead(busRead),
    .busDataOut(busDataOut), .busReady(busReady), .syncStart(syncStart)
  );

  always #5 apbPclk = ~apbPclk;

  typedef struct packed {
    logic       isB;
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          readyDelay = 0;
  int          strobeRun = 0;
  int          lastLen = 0;
  logic [17:0] lastAddr = '0;
  logic [7:0]  lastData = '0;
  int          cycleNo = 0;
  int          syncCount = 0;
  int          syncCycle = 0;
  int          doneACycle = 0;
  int          doneBCycle = 0;
  logic        overlapSeen = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  // Bus responder and monitor: everything sampled on the falling edge.
  always @(negedge apbPclk) begin
    exp_t e;
    cycleNo++;
    if (busWrite && busRead) overlapSeen = 1'b1;
    if (busWrite || busRead) begin
      strobeRun++;
      lastAddr = busAddr;
      lastData = busDataIn;
    end else begin
      if (strobeRun != 0) lastLen = strobeRun;
      strobeRun = 0;
    end
    busReady = (busWrite || busRead) && readyDelay != 0 && strobeRun == readyDelay;
    if (syncStart) begin
      syncCount++;
      syncCycle = cycleNo;
    end
    if (doneA) doneACycle = cycleNo;
    if (doneB) doneBCycle = cycleNo;
    if (doneA || doneB) begin
      check("one_done", 32'(doneA & doneB), 0);
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'(doneA | doneB), 0);
      end else begin
        e = sbq.pop_front();
        check("grant_b", 32'(doneB), 32'(e.isB));
        check("err", 32'(doneB ? errB : errA), 32'(e.err));
        check("rdata", 32'(rdata), 32'(e.data));
      end
    end
  end

  task automatic waitDone(input string tag);
    int n = 0;
    do begin
      @(negedge apbPclk);
      n++;
    end while (!(doneA || doneB) && n < 200);
    if (!(doneA || doneB)) check({tag, "_timeout"}, 32'(doneA | doneB), 1);
  endtask

  task automatic waitStrobe(input string tag);
    int n = 0;
    do begin
      @(negedge apbPclk);
      n++;
    end while (!(busWrite || busRead) && n < 200);
    if (!(busWrite || busRead)) check({tag, "_timeout"}, 32'(busWrite | busRead), 1);
  endtask

  initial begin
    int syncBefore;
    // Reset state
    repeat (3) @(negedge apbPclk);
    check("rst_write", 32'(busWrite), 0);
    check("rst_read", 32'(busRead), 0);
    check("rst_done", 32'({doneA, doneB, errA, errB}), 0);
    check("rst_sync", 32'(syncStart), 0);
    check("rst_addr", 32'(busAddr), 0);
    check("rst_rdata", 32'(rdata), 0);
    apbPresern = 1'b1;
    @(negedge apbPclk);

    // A write, ready after two strobe cycles
    readyDelay = 2;
    addrA = 18'h00010; wdataA = 8'h5A; wrA = 1'b1; reqA = 1'b1;
    sbq.push_back('{isB: 1'b0, err: 1'b0, data: 8'h00});
    waitDone("wr_a");
    reqA = 1'b0;
    @(negedge apbPclk);
    check("wr_len", 32'(lastLen), 2);
    check("wr_addr", 32'(lastAddr), 32'h10);
    check("wr_data", 32'(lastData), 32'h5A);

    // B read returns bus data
    readyDelay = 1;
    busDataOut = 8'hC3;
    addrB = 18'h2ABCD; wrB = 1'b0; reqB = 1'b1;
    sbq.push_back('{isB: 1'b1, err: 1'b0, data: 8'hC3});
    waitDone("rd_b");
    reqB = 1'b0;
    @(negedge apbPclk);
    check("rd_len", 32'(lastLen), 1);
    check("rd_addr", 32'(lastAddr), 32'h2ABCD);

    // Both held: alternate A,B,A,B
    busDataOut = 8'h77;
    wrA = 1'b0; reqA = 1'b1; reqB = 1'b1;
    for (int i = 0; i < 4; i++) sbq.push_back('{isB: 1'(i % 2), err: 1'b0, data: 8'h77});
    for (int i = 0; i < 4; i++) waitDone("rr");
    reqA = 1'b0; reqB = 1'b0;
    repeat (2) @(negedge apbPclk);

    // Timeout with busReady held low
    readyDelay = 0;
    busDataOut = 8'hEE;
    wrA = 1'b0; reqA = 1'b1;
    sbq.push_back('{isB: 1'b0, err: 1'b1, data: 8'h00});
    waitDone("tmo");
    reqA = 1'b0;
    repeat (2) @(negedge apbPclk);
    check("tmo_len", 32'(lastLen), 4);
    check("tmo_idle", 32'(busRead | busWrite), 0);

    // Commit during an A access, with B queued behind it
    readyDelay = 3;
    busDataOut = 8'h3C;
    syncBefore = syncCount;
    reqA = 1'b1;
    sbq.push_back('{isB: 1'b0, err: 1'b0, data: 8'h3C});
    sbq.push_back('{isB: 1'b1, err: 1'b0, data: 8'h3C});
    waitStrobe("cm_strobe");
    commitB = 1'b1; reqB = 1'b1;
    @(negedge apbPclk);
    commitB = 1'b0;
    check("cm_no_early_sync", 32'(syncCount - syncBefore), 0);
    waitDone("cm_a");
    reqA = 1'b0;
    waitDone("cm_b");
    reqB = 1'b0;
    @(negedge apbPclk);
    check("cm_sync_once", 32'(syncCount - syncBefore), 1);
    check("cm_sync_after_a", 32'(syncCycle - doneACycle), 1);
    check("cm_b_after_sync", 32'(doneBCycle > syncCycle), 1);

    // Leave the pointer at B, then reset in the middle of an A access
    readyDelay = 1;
    wrA = 1'b1; reqA = 1'b1;
    sbq.push_back('{isB: 1'b0, err: 1'b0, data: 8'h00});
    waitDone("pre_rst");
    reqA = 1'b0;
    @(negedge apbPclk);
    readyDelay = 0;
    reqA = 1'b1;
    waitStrobe("rst_strobe");
    #2 apbPresern = 1'b0;
    #1 check("rst_async_strobe", 32'(busWrite | busRead), 0);
    reqA = 1'b0;
    repeat (3) @(negedge apbPclk);
    apbPresern = 1'b1;
    @(negedge apbPclk);
    readyDelay = 1;
    reqA = 1'b1; reqB = 1'b1; wrB = 1'b1;
    sbq.push_back('{isB: 1'b0, err: 1'b0, data: 8'h00});
    sbq.push_back('{isB: 1'b1, err: 1'b0, data: 8'h00});
    waitDone("post_rst_a");
    reqA = 1'b0;
    waitDone("post_rst_b");
    reqB = 1'b0;
    repeat (3) @(negedge apbPclk);

    check("sb_empty", 32'(sbq.size()), 0);
    check("strobe_excl", 32'(overlapSeen), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
